// File: rtl/multdiv_ctrl.sv
// Sequencer between the execute stage and the shared multiply/divide unit:
// latches one instruction, pulses start, stalls until ready, writes back once.
module multdiv_ctrl #(
    parameter int          TIMEOUT       = 64,
    parameter logic [4:0]  EXC_REG       = 5'd30,
    parameter logic [31:0] MULT_EXC_CODE = 32'd4,
    parameter logic [31:0] DIV_EXC_CODE  = 32'd5
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic [4:0]  issue_rd,
    input  logic        flush,

    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,

    output logic        stall,
    output logic        busy,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic             is_div_q;
    logic [4:0]       rd_q;
    logic [31:0]      result_q;
    logic             exc_q;
    logic [CNT_W-1:0] count;

    // A flush anywhere past IDLE abandons the run; the unit is restarted by the next start pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            count    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue_valid && !flush) begin
                        a_q      <= issue_a;
                        b_q      <= issue_b;
                        is_div_q <= issue_is_div;
                        rd_q     <= issue_rd;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    count <= '0;
                    state <= flush ? S_IDLE : S_BUSY;
                end
                S_BUSY: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        count <= count + CNT_W'(1);
                        if (md_resultRDY) begin
                            result_q <= md_result;
                            exc_q    <= md_exception;
                            state    <= S_DONE;
                        end else if (count == CNT_LAST) begin
                            exc_q <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The IDLE stall path is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        md_operandA  = a_q;
        md_operandB  = b_q;
        md_ctrl_MULT = (state == S_START) && !is_div_q;
        md_ctrl_DIV  = (state == S_START) && is_div_q;
        busy         = (state != S_IDLE);
        stall        = 1'b0;
        case (state)
            S_IDLE:  stall = reset_n && issue_valid && !flush;
            S_START: stall = 1'b1;
            S_BUSY:  stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    always_comb begin
        wb_valid     = (state == S_DONE) && !flush;
        wb_rd        = '0;
        wb_data      = '0;
        wb_exception = 1'b0;
        if (wb_valid) begin
            if (exc_q) begin
                wb_rd        = EXC_REG;
                wb_data      = is_div_q ? DIV_EXC_CODE : MULT_EXC_CODE;
                wb_exception = 1'b1;
            end else begin
                wb_rd        = rd_q;
                wb_data      = result_q;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: a behavioural unit stub plus a timeline model of the
// expected outputs, checked every cycle, with literal pins on key results.
module tb_multdiv_ctrl;

    localparam int TIMEOUT = 64;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_is_div = 1'b0;
    logic [31:0] issue_a = '0;
    logic [31:0] issue_b = '0;
    logic [4:0]  issue_rd = '0;
    logic        flush = 1'b0;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic [31:0] md_result = 32'hDEADBEEF;
    logic        md_exception = 1'b1;
    logic        md_resultRDY = 1'b0;
    logic        stall;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;

    multdiv_ctrl #(
        .TIMEOUT(TIMEOUT), .EXC_REG(5'd30),
        .MULT_EXC_CODE(32'd4), .DIV_EXC_CODE(32'd5)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_is_div(issue_is_div),
        .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd),
        .flush(flush),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
        .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
        .stall(stall), .busy(busy),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exception(wb_exception)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Arithmetic the multiply/divide unit performs, signed 32-bit semantics.
    function automatic void unit_calc(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] val, output bit exc);
        longint p;
        val = '0;
        exc = 1'b0;
        if (!is_div) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            val = p[31:0];
            exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            exc = 1'b1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            exc = 1'b1;
        end else begin
            val = $signed(a) / $signed(b);
        end
    endfunction

    // Unit stub: ready stub_lat cycles after the start pulse; 0 means never ready.
    int          stub_lat = 0;
    int          stub_cnt = 0;
    bit          stub_force = 1'b0;
    bit          stub_div;
    logic [31:0] stub_a, stub_b, stub_val;
    bit          stub_exc;

    always @(negedge clock) begin
        md_resultRDY = stub_force;
        md_result    = 32'hDEADBEEF;
        md_exception = 1'b1;
        if (!reset_n) begin
            stub_cnt = 0;
        end else if (md_ctrl_MULT || md_ctrl_DIV) begin
            stub_cnt = stub_lat;
            stub_div = md_ctrl_DIV;
            stub_a   = md_operandA;
            stub_b   = md_operandB;
        end else if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                unit_calc(stub_div, stub_a, stub_b, stub_val, stub_exc);
                md_result    = stub_val;
                md_exception = stub_exc;
                md_resultRDY = 1'b1;
            end
        end
    end

    // Timeline model of the current operation.
    int          win_lo = -100;
    int          win_hi = -100;
    int          wb_cyc = -1;
    bit          flushed = 1'b0;
    bit          cur_div = 1'b0;
    logic [31:0] cur_a = '0, cur_b = '0, prev_a = '0, prev_b = '0;
    logic [4:0]  exp_rd = '0;
    logic [31:0] exp_data = '0;
    bit          exp_exc = 1'b0;
    bit          chk_en = 1'b0;

    int          mult_pulses = 0, div_pulses = 0, stall_cnt = 0, wb_count = 0, last_wb_cyc = -1;
    logic [31:0] last_wb_data = '0;
    logic [4:0]  last_wb_rd = '0;
    bit          last_wb_exc = 1'b0;

    bit          e_busy, e_stall, e_mult, e_div, e_wbv;

    always @(negedge clock) begin
        if (chk_en) begin
            e_busy  = (cyc > win_lo) && (cyc <= win_hi);
            e_stall = ((cyc >= win_lo) && (cyc < win_hi)) || (flushed && (cyc == win_hi));
            e_mult  = (cyc == win_lo + 1) && !cur_div;
            e_div   = (cyc == win_lo + 1) && cur_div;
            e_wbv   = (cyc == wb_cyc);
            check_output("busy", 32'(busy), 32'(e_busy));
            check_output("stall", 32'(stall), 32'(e_stall));
            check_output("md_ctrl_MULT", 32'(md_ctrl_MULT), 32'(e_mult));
            check_output("md_ctrl_DIV", 32'(md_ctrl_DIV), 32'(e_div));
            check_output("md_operandA", md_operandA, (cyc > win_lo) ? cur_a : prev_a);
            check_output("md_operandB", md_operandB, (cyc > win_lo) ? cur_b : prev_b);
            check_output("wb_valid", 32'(wb_valid), 32'(e_wbv));
            check_output("wb_rd", 32'(wb_rd), e_wbv ? 32'(exp_rd) : 32'd0);
            check_output("wb_data", wb_data, e_wbv ? exp_data : 32'd0);
            check_output("wb_exception", 32'(wb_exception), e_wbv ? 32'(exp_exc) : 32'd0);
        end
        if (md_ctrl_MULT) mult_pulses++;
        if (md_ctrl_DIV) div_pulses++;
        if (stall) stall_cnt++;
        if (wb_valid) begin
            wb_count++;
            last_wb_cyc  = cyc;
            last_wb_data = wb_data;
            last_wb_rd   = wb_rd;
            last_wb_exc  = wb_exception;
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic begin_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input int lat);
        logic [31:0] val;
        bit          uexc;
        bit          tmo;
        tmo    = (lat <= 0) || (lat > TIMEOUT);
        prev_a = cur_a;
        prev_b = cur_b;
        cur_a  = a;
        cur_b  = b;
        cur_div = is_div;
        flushed = 1'b0;
        win_lo = cyc;
        wb_cyc = tmo ? cyc + TIMEOUT + 2 : cyc + lat + 2;
        win_hi = wb_cyc;
        unit_calc(is_div, a, b, val, uexc);
        if (tmo || uexc) begin
            exp_rd   = 5'd30;
            exp_data = is_div ? 32'd5 : 32'd4;
            exp_exc  = 1'b1;
        end else begin
            exp_rd   = rd;
            exp_data = val;
            exp_exc  = 1'b0;
        end
        stub_lat    = lat;
        stall_cnt   = 0;
        mult_pulses = 0;
        div_pulses  = 0;
        issue_valid  = 1'b1;
        issue_is_div = is_div;
        issue_a      = a;
        issue_b      = b;
        issue_rd     = rd;
    endtask

    // Issues one op and holds it in execute until the cycle after its writeback.
    task automatic apply_stimulus(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] rd, input int lat, input bit wiggle);
        int stop;
        begin_op(is_div, a, b, rd, lat);
        stop = wb_cyc + 1;
        while (cyc < stop) begin
            next_cycle();
            if (wiggle && cyc > win_lo + 1) begin
                issue_a = $urandom;
                issue_b = $urandom;
            end
        end
        issue_valid = 1'b0;
    endtask

    int base_wb;

    initial begin
        chk_en = 1'b1;
        next_cycle();
        next_cycle();
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_wb_valid", 32'(wb_valid), 32'd0);
        check_output("reset_operandA", md_operandA, 32'd0);
        reset_n = 1'b1;
        next_cycle();

        apply_stimulus(1'b0, 32'h00000007, 32'hFFFFFFFA, 5'd3, 3, 1'b0);
        check_output("mul_data", last_wb_data, 32'hFFFFFFD6);
        check_output("mul_rd", 32'(last_wb_rd), 32'd3);
        check_output("mul_exc", 32'(last_wb_exc), 32'd0);
        check_output("mul_pulses", 32'(mult_pulses), 32'd1);
        check_output("mul_div_pulses", 32'(div_pulses), 32'd0);
        check_output("mul_stall_len", 32'(stall_cnt), 32'd5);
        check_output("mul_latency", 32'(last_wb_cyc - win_lo), 32'd5);
        next_cycle();

        apply_stimulus(1'b1, 32'd100, 32'd7, 5'd9, 5, 1'b1);
        check_output("div_data", last_wb_data, 32'd14);
        check_output("div_rd", 32'(last_wb_rd), 32'd9);
        check_output("div_pulses", 32'(div_pulses), 32'd1);
        check_output("div_hold_A", md_operandA, 32'd100);
        check_output("div_hold_B", md_operandB, 32'd7);

        apply_stimulus(1'b1, 32'd1, 32'd0, 5'd8, 2, 1'b0);
        check_output("div0_rd", 32'(last_wb_rd), 32'd30);
        check_output("div0_data", last_wb_data, 32'd5);
        check_output("div0_exc", 32'(last_wb_exc), 32'd1);

        apply_stimulus(1'b0, 32'h00010000, 32'h00010000, 5'd11, 1, 1'b0);
        check_output("movf_rd", 32'(last_wb_rd), 32'd30);
        check_output("movf_data", last_wb_data, 32'd4);

        apply_stimulus(1'b0, 32'd9, 32'd9, 5'd4, 0, 1'b0);
        check_output("mtmo_data", last_wb_data, 32'd4);
        check_output("mtmo_exc", 32'(last_wb_exc), 32'd1);
        check_output("mtmo_cycles", 32'(last_wb_cyc - (win_lo + 2)), 32'd64);

        apply_stimulus(1'b1, 32'd9, 32'd3, 5'd4, 0, 1'b0);
        check_output("dtmo_data", last_wb_data, 32'd5);
        check_output("dtmo_rd", 32'(last_wb_rd), 32'd30);

        apply_stimulus(1'b0, 32'd2, 32'd3, 5'd5, TIMEOUT, 1'b0);
        check_output("rdy_at_tmo_data", last_wb_data, 32'd6);
        check_output("rdy_at_tmo_exc", 32'(last_wb_exc), 32'd0);

        base_wb = wb_count;
        apply_stimulus(1'b0, 32'd2, 32'd2, 5'd0, 2, 1'b0);
        check_output("r0_wb_count", 32'(wb_count - base_wb), 32'd1);
        check_output("r0_data", last_wb_data, 32'd4);
        next_cycle();

        // Flush three cycles into BUSY, then issue immediately behind it.
        base_wb = wb_count;
        begin_op(1'b0, 32'd3, 32'd5, 5'd7, 4);
        repeat (4) next_cycle();
        flush   = 1'b1;
        flushed = 1'b1;
        win_hi  = cyc;
        wb_cyc  = -1;
        next_cycle();
        flush = 1'b0;
        check_output("flush_no_wb", 32'(wb_count - base_wb), 32'd0);
        apply_stimulus(1'b1, 32'd50, 32'hFFFFFFFB, 5'd12, 3, 1'b0);
        check_output("b2b_data", last_wb_data, 32'hFFFFFFF6);
        check_output("b2b_rd", 32'(last_wb_rd), 32'd12);
        check_output("b2b_wb_count", 32'(wb_count - base_wb), 32'd1);

        // Asynchronous reset between clock edges in the middle of BUSY.
        base_wb = wb_count;
        begin_op(1'b0, 32'd6, 32'd7, 5'd13, 10);
        repeat (3) next_cycle();
        #2;
        reset_n     = 1'b0;
        issue_valid = 1'b0;
        cur_a = '0; cur_b = '0; prev_a = '0; prev_b = '0;
        win_lo = -100; win_hi = -100; wb_cyc = -1; flushed = 1'b0;
        #1;
        check_output("arst_busy", 32'(busy), 32'd0);
        check_output("arst_stall", 32'(stall), 32'd0);
        check_output("arst_mult", 32'(md_ctrl_MULT), 32'd0);
        check_output("arst_operandA", md_operandA, 32'd0);
        check_output("arst_operandB", md_operandB, 32'd0);
        check_output("arst_wb_valid", 32'(wb_valid), 32'd0);
        next_cycle();
        stub_force = 1'b1;
        next_cycle();
        reset_n = 1'b1;
        repeat (2) next_cycle();
        stub_force = 1'b0;
        next_cycle();
        check_output("arst_stale_no_wb", 32'(wb_count - base_wb), 32'd0);

        apply_stimulus(1'b0, 32'd5, 32'd5, 5'd14, 2, 1'b0);
        check_output("post_rst_data", last_wb_data, 32'd25);
        check_output("post_rst_rd", 32'(last_wb_rd), 32'd14);

        repeat (3) next_cycle();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequencer between the processor's execute stage and the shared multiply/divide unit.
- Accepts one mult/div instruction at a time and latches its operands and destination. Issues a single-cycle start pulse, holds operands stable, and stalls the pipeline until the unit reports ready.
- Produces one writeback beat carrying either the result or the status-register exception code. Also covers flush, watchdog timeout and reset mid-operation.

Parameters:
- TIMEOUT, 64, max cycles spent in BUSY before forced completion with exception.
- EXC_REG, 30, destination register for exception writes.
- MULT_EXC_CODE, 4, value written to EXC_REG on multiply exception or multiply timeout.
- DIV_EXC_CODE, 5, value written to EXC_REG on divide exception or divide timeout.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- issue_valid  input  1  execute stage holds a mult/div instruction.
- issue_is_div  input  1  1 = divide, 0 = multiply.
- issue_a  input  32  operand A / dividend.
- issue_b  input  32  operand B / divisor.
- issue_rd  input  5  destination register.
- flush  input  1  squash the in-flight operation.
- md_operandA  output  32  to unit data_operandA; latched value.
- md_operandB  output  32  to unit data_operandB; latched value.
- md_ctrl_MULT  output  1  start pulse to unit.
- md_ctrl_DIV  output  1  start pulse to unit.
- md_result  input  32  unit data_result.
- md_exception  input  1  unit data_exception.
- md_resultRDY  input  1  unit data_resultRDY.
- stall  output  1  freeze fetch/decode/execute.
- busy  output  1  state != IDLE.
- wb_valid  output  1  one-cycle writeback strobe.
- wb_rd  output  5  writeback register.
- wb_data  output  32  writeback value.
- wb_exception  output  1  this writeback is an exception write.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE; all latched registers and the counter clear to 0.
  - All outputs read 0: md_*, stall, busy, wb_*.
- States: IDLE, START, BUSY, DONE. Encoding is free.
- IDLE:
  - If issue_valid=1 and flush=0: latch a, b, is_div, rd; go to START.
  - stall is combinational: stall = issue_valid & ~flush, so the instruction holds in execute the same cycle.
- START (exactly 1 cycle):
  - md_ctrl_MULT = ~is_div_q; md_ctrl_DIV = is_div_q. Both are 0 in every other state.
  - Counter clears. md_resultRDY is ignored here, since it may be stale from the previous op.
  - Go to BUSY.
- BUSY:
  - Counter increments each cycle.
  - If md_resultRDY=1: capture md_result and md_exception; go to DONE.
  - Else if counter == TIMEOUT-1: force exception=1; go to DONE.
  - md_resultRDY has priority when it coincides with the timeout cycle.
- DONE (1 cycle):
  - wb_valid=1 and stall=0, so the pipeline advances this cycle. Then go to IDLE.
  - issue_valid seen in DONE is the same instruction and is ignored; no re-issue.
- stall = 1 in START and BUSY; 0 in DONE.
- busy = 1 in START, BUSY and DONE.
- md_operandA/B are driven from the latched registers in all states. They are stable from START through DONE regardless of issue_a/b changes.
- Writeback:
  - No exception: wb_rd = rd_q, wb_data = captured result, wb_exception = 0.
  - Exception: wb_rd = EXC_REG, wb_data = DIV_EXC_CODE if is_div_q else MULT_EXC_CODE, wb_exception = 1.
  - wb_rd, wb_data and wb_exception are 0 whenever wb_valid = 0.
  - rd_q = 0 with no exception still produces wb_valid; the register file discards writes to r0.
- flush=1 in START, BUSY or DONE:
  - Next state is IDLE with no writeback; wb_valid is forced to 0 that cycle.
  - The unit's internal run is abandoned; its late resultRDY is ignored.
  - The next START pulse restarts the unit.
- Latency: with the unit ready K cycles after the start pulse, wb_valid asserts K+1 cycles after START, and stall spans K+2 cycles from the issue cycle.

Test Plan:
- Multiply 7 × -6 (0x00000007, 0xFFFFFFFA), rd=3 -> exactly one md_ctrl_MULT pulse; stall high until DONE; wb_valid one cycle with wb_rd=3, wb_data=0xFFFFFFD6, wb_exception=0.
- Divide 100 ÷ 7, rd=9 -> one md_ctrl_DIV pulse; wb_data=14, wb_rd=9. Toggling issue_a/b during BUSY leaves md_operandA/B at 100/7.
- Divide by zero -> wb_rd=30, wb_data=5, wb_exception=1. Multiply 0x00010000 × 0x00010000 (overflow) -> wb_rd=30, wb_data=4.
- Stub unit never raises md_resultRDY -> wb_valid with exception exactly TIMEOUT cycles after entering BUSY; multiply writes code 4, divide writes code 5.
- flush asserted 3 cycles into BUSY -> IDLE next cycle, no wb_valid, late md_resultRDY ignored. A back-to-back issue afterwards completes correctly.
- reset_n dropped mid-BUSY, asynchronously between clock edges -> all outputs 0 immediately, state IDLE. A stale md_resultRDY at release produces no writeback.
